// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Ports: clock/reset/run, opcode, branch_taken, mem_ready in; datapath enables, selects, status out.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             alu_src_b,
  output logic             wb_sel,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state_q, state_d;
  logic   fetch_first;
  logic   illegal_q;
  logic   set_illegal;
  logic   is_r, is_i, is_load, is_store, is_branch, is_sys;
  logic   imm_b;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_sys    = (opcode == OP_SYSTEM);
  assign imm_b     = is_i | is_load | is_store;

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    alu_src_b   = 1'b0;
    wb_sel      = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    set_illegal = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        // run dropped on the entry cycle: back out before a request exists
        if (fetch_first && !run) begin
          state_d = IDLE;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        if (is_sys) begin
          state_d = HALT;
        end else if (is_r | is_i | is_load | is_store | is_branch) begin
          state_d = EXEC;
        end else begin
          state_d     = HALT;
          set_illegal = 1'b1;
        end
      end
      EXEC: begin
        alu_src_b = imm_b;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken;
          state_d = FETCH;
        end else if (is_load | is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        alu_src_b = 1'b1;
        mem_we    = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_we    = 1'b1;
        wb_sel    = is_load;
        alu_src_b = imm_b;
        pc_we     = 1'b1;
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // write enables must not fire in a reset cycle
    if (reset) begin
      ir_we       = 1'b0;
      mdr_we      = 1'b0;
      reg_we      = 1'b0;
      pc_we       = 1'b0;
      set_illegal = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_first  <= 1'b0;
      illegal_q    <= 1'b0;
      retire_count <= '0;
    end else begin
      state_q     <= state_d;
      fetch_first <= (state_d == FETCH) && (state_q != FETCH);
      if (set_illegal) illegal_q <= 1'b1;
      if (pc_we) retire_count <= retire_count + 1'b1;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control vectors.
// Narrow retire counter so the wrap case is reachable.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset, run, branch_taken, mem_ready;
  logic [6:0]    opcode;
  logic          mem_req, mem_we, addr_sel, ir_we, mdr_we;
  logic          alu_src_b, wb_sel, reg_we, pc_we, pc_sel;
  logic          halted, illegal;
  logic [2:0]    state;
  logic [CW-1:0] retire_count;
  int            n_run = 0;
  int            n_fail = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .illegal(illegal), .state(state),
    .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  // {mem_req,mem_we,addr_sel,ir_we,mdr_we,alu_src_b,wb_sel,reg_we,pc_we,pc_sel}
  wire [9:0] ctl = {mem_req, mem_we, addr_sel, ir_we, mdr_we,
                    alu_src_b, wb_sel, reg_we, pc_we, pc_sel};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b0; opcode = 7'd0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clock);
    n_run++;
    if (state !== 3'd0 || ctl !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_out state=%0d ctl=%b want 0/%b", state, ctl, 10'd0);
    end
    n_run++;
    if (retire_count !== '0 || halted !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stat cnt=%0d h=%b i=%b want 0 0 0",
               retire_count, halted, illegal);
    end
  endtask

  task automatic test_r_type;
    logic [2:0] es [5] = '{1, 2, 3, 5, 1};
    logic [9:0] ec [5] = '{10'b1001000000, 10'b0, 10'b0,
                           10'b0000000110, 10'b1001000000};
    do_reset;
    run = 1'b1; opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      tick;
      mem_ready = 1'b1;
      @(negedge clock);
      n_run++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_fail++;
        $display("FAIL add c%0d state=%0d ctl=%b want %0d/%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
    n_run++;
    if (retire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL add_retire got %0d want 1", retire_count);
    end
  endtask

  task automatic test_load_wait;
    logic [2:0] es [10] = '{1, 1, 1, 2, 3, 4, 4, 4, 5, 1};
    logic       rd [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 0};
    logic [9:0] ec [10] = '{10'b1000000000, 10'b1000000000,
                            10'b1001000000, 10'b0000000000,
                            10'b0000010000, 10'b1010010000,
                            10'b1010010000, 10'b1010110000,
                            10'b0000011110, 10'b1000000000};
    do_reset;
    run = 1'b1; opcode = 7'b0000011;
    for (int i = 0; i < 10; i++) begin
      tick;
      mem_ready = rd[i];
      @(negedge clock);
      n_run++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_fail++;
        $display("FAIL lw c%0d state=%0d ctl=%b want %0d/%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
    n_run++;
    if (retire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL lw_retire got %0d want 1", retire_count);
    end
  endtask

  task automatic test_branch;
    logic [2:0] es [7] = '{1, 2, 3, 1, 2, 3, 1};
    logic       bt [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [9:0] ec [7] = '{10'b1001000000, 10'b0, 10'b0000000011,
                           10'b1001000000, 10'b0, 10'b0000000010,
                           10'b1001000000};
    do_reset;
    run = 1'b1; opcode = 7'b1100011;
    for (int i = 0; i < 7; i++) begin
      tick;
      mem_ready = 1'b1;
      branch_taken = bt[i];
      @(negedge clock);
      n_run++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_fail++;
        $display("FAIL beq c%0d state=%0d ctl=%b want %0d/%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
    n_run++;
    if (retire_count !== 4'd2) begin
      n_fail++;
      $display("FAIL beq_retire got %0d want 2", retire_count);
    end
  endtask

  task automatic test_store;
    logic [2:0] es [6] = '{1, 2, 3, 4, 4, 1};
    logic       rd [6] = '{1, 0, 0, 0, 1, 0};
    logic [9:0] ec [6] = '{10'b1001000000, 10'b0, 10'b0000010000,
                           10'b1110010000, 10'b1110010010,
                           10'b1000000000};
    do_reset;
    run = 1'b1; opcode = 7'b0100011;
    for (int i = 0; i < 6; i++) begin
      tick;
      mem_ready = rd[i];
      @(negedge clock);
      n_run++;
      if (state !== es[i] || ctl !== ec[i]) begin
        n_fail++;
        $display("FAIL sw c%0d state=%0d ctl=%b want %0d/%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
    n_run++;
    if (retire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sw_retire got %0d want 1", retire_count);
    end
  endtask

  task automatic test_fetch_abort;
    do_reset;
    run = 1'b1;
    tick;
    run = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    n_run++;
    if (state !== 3'd1 || mem_req !== 1'b0 || ir_we !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_entry state=%0d req=%b irwe=%b want 1 0 0",
               state, mem_req, ir_we);
    end
    tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_idle state=%0d want 0", state);
    end
  endtask

  task automatic test_halt;
    logic bad;
    do_reset;
    run = 1'b1; opcode = 7'b0000000; mem_ready = 1'b1;
    repeat (3) tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_ill state=%0d h=%b i=%b want 6 1 1",
               state, halted, illegal);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      @(negedge clock);
      if (state !== 3'd6 || ctl !== 10'd0 || halted !== 1'b1) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0 || retire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL halt_hold leaked=%b cnt=%0d want 0 0", bad, retire_count);
    end
    do_reset;
    @(negedge clock);
    n_run++;
    if (illegal !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clear h=%b i=%b want 0 0", halted, illegal);
    end
    run = 1'b1; opcode = 7'b1110011; mem_ready = 1'b1;
    repeat (2) tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd2 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL ecall_dec state=%0d h=%b want 2 0", state, halted);
    end
    tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd6 || halted !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL ecall_halt state=%0d h=%b i=%b want 6 1 0",
               state, halted, illegal);
    end
  endtask

  task automatic test_reset_mid_fetch;
    do_reset;
    run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    repeat (5) tick;
    mem_ready = 1'b0;
    tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd1 || mem_req !== 1'b1 || retire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_pre state=%0d req=%b cnt=%0d want 1 1 1",
               state, mem_req, retire_count);
    end
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    n_run++;
    if (ir_we !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rstcyc irwe=%b pcwe=%b regwe=%b want 0 0 0",
               ir_we, pc_we, reg_we);
    end
    tick;
    reset = 1'b0;
    @(negedge clock);
    n_run++;
    if (state !== 3'd0 || mem_req !== 1'b0 || retire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_post state=%0d req=%b cnt=%0d want 0 0 0",
               state, mem_req, retire_count);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    run = 1'b1; opcode = 7'b1100011; mem_ready = 1'b1;
    repeat (46) tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd1 || retire_count !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_pre state=%0d cnt=%0d want 1 15", state, retire_count);
    end
    repeat (3) tick;
    @(negedge clock);
    n_run++;
    if (state !== 3'd1 || retire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_post state=%0d cnt=%0d want 1 0", state, retire_count);
    end
  endtask

  initial begin
    test_reset;
    test_r_type;
    test_load_wait;
    test_branch;
    test_store;
    test_fetch_abort;
    test_halt;
    test_reset_mid_fetch;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
